// File: rtl/mac_datapath.sv
// Datapath of a sequenced multiply-accumulate unit: operand capture, product
// register, accumulator with sticky carry flag, element counter and result register.
module mac_datapath #(
    parameter int DATA_W = 8,
    parameter int LEN    = 4,
    parameter int ADDR_W = 3,
    parameter int ACC_W  = 2*DATA_W + ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_a,
    input  logic              load_b,
    input  logic              load_m,
    input  logic              load_acc,
    input  logic              load_out,
    input  logic              count_enable,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    output logic [ADDR_W-1:0] addr,
    output logic              cmp,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] LEN_C = ADDR_W'(LEN);

    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [2*DATA_W-1:0] m_q, m_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic [ACC_W-1:0]    result_q, result_d;
    logic                rv_q, rv_d;
    logic                ovf_q, ovf_d;
    logic                ovf_res_q, ovf_res_d;

    logic [2*DATA_W-1:0] prod_w;
    logic [ACC_W:0]      acc_sum_w;

    assign prod_w    = (2*DATA_W)'(a_q) * (2*DATA_W)'(b_q);
    assign acc_sum_w = {1'b0, acc_q} + (ACC_W+1)'(m_q);

    always_comb begin
        a_d       = load_a ? a_data : a_q;
        b_d       = load_b ? b_data : b_q;
        m_d       = load_m ? prod_w : m_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        count_d   = count_q;
        result_d  = result_q;
        ovf_res_d = ovf_res_q;
        rv_d      = 1'b0;

        if (load_acc) begin
            acc_d = acc_sum_w[ACC_W-1:0];
            ovf_d = ovf_q | acc_sum_w[ACC_W];
        end
        if (count_enable && (count_q < LEN_C)) begin
            count_d = count_q + ADDR_W'(1);
        end

        // load_out wins over concurrent accumulate/count and starts a fresh operation.
        if (load_out) begin
            result_d  = acc_q;
            ovf_res_d = ovf_q;
            rv_d      = 1'b1;
            acc_d     = '0;
            count_d   = '0;
            ovf_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            m_q       <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            result_q  <= '0;
            rv_q      <= 1'b0;
            ovf_q     <= 1'b0;
            ovf_res_q <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            result_q  <= result_d;
            rv_q      <= rv_d;
            ovf_q     <= ovf_d;
            ovf_res_q <= ovf_res_d;
        end
    end

    // result_valid is a one-cycle pulse with no backpressure: result and the
    // overflow copy are meaningful only in the cycle it is high.
    assign addr         = count_q;
    assign cmp          = (count_q == LEN_C);
    assign result       = result_q;
    assign result_valid = rv_q;
    assign overflow     = rv_q ? ovf_res_q : ovf_q;

endmodule

// File: tb/tb_mac_datapath.sv
// Directed bench for mac_datapath: a default-width instance and a 16-bit
// accumulator instance share commands and operands; results are scoreboarded.
module tb_mac_datapath;

    localparam logic [5:0] LA   = 6'd1;
    localparam logic [5:0] LB   = 6'd2;
    localparam logic [5:0] LM   = 6'd4;
    localparam logic [5:0] LACC = 6'd8;
    localparam logic [5:0] LOUT = 6'd16;
    localparam logic [5:0] CE   = 6'd32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_a = 0, load_b = 0, load_m = 0, load_acc = 0, load_out = 0, count_enable = 0;
    logic [7:0]  a_data, b_data;
    logic [2:0]  addr1, addr2;
    logic        cmp1, cmp2;
    logic [18:0] result1;
    logic [15:0] result2;
    logic        rv1, rv2, ovf1, ovf2;

    logic [7:0]  mem_a [0:7];
    logic [7:0]  mem_b [0:7];

    logic [19:0] exp1_q[$];
    logic [16:0] exp2_q[$];

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_cnt      = 0;

    always #5 clk = ~clk;

    assign a_data = mem_a[addr1];
    assign b_data = mem_b[addr1];

    mac_datapath dut1 (
        .clk(clk), .rst(rst),
        .load_a(load_a), .load_b(load_b), .load_m(load_m),
        .load_acc(load_acc), .load_out(load_out), .count_enable(count_enable),
        .a_data(a_data), .b_data(b_data),
        .addr(addr1), .cmp(cmp1), .result(result1),
        .result_valid(rv1), .overflow(ovf1)
    );

    mac_datapath #(.ACC_W(16)) dut2 (
        .clk(clk), .rst(rst),
        .load_a(load_a), .load_b(load_b), .load_m(load_m),
        .load_acc(load_acc), .load_out(load_out), .count_enable(count_enable),
        .a_data(a_data), .b_data(b_data),
        .addr(addr2), .cmp(cmp2), .result(result2),
        .result_valid(rv2), .overflow(ovf2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Drive one cycle of commands; returns at the following negedge.
    task automatic cyc(input logic [5:0] c);
        {count_enable, load_out, load_acc, load_m, load_b, load_a} = c;
        @(negedge clk);
        {count_enable, load_out, load_acc, load_m, load_b, load_a} = '0;
    endtask

    task automatic load_vec(input logic [31:0] av, input logic [31:0] bv);
        for (int i = 0; i < 8; i++) begin
            mem_a[i] = (i < 4) ? av[8*i +: 8] : 8'd0;
            mem_b[i] = (i < 4) ? bv[8*i +: 8] : 8'd0;
        end
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            check("addr_step", {29'd0, addr1}, exp_cnt);
            check("addr_match", {29'd0, addr2}, exp_cnt);
            cyc(LA | LB | CE);
            if (exp_cnt < 4) exp_cnt++;
            check("cmp_after_ce", {31'd0, cmp1}, (exp_cnt == 4) ? 1 : 0);
            cyc(LM);
            cyc(LACC);
        end
    endtask

    task automatic finish_op(input logic [18:0] r1, input logic o1, input logic [15:0] r2, input logic o2);
        exp1_q.push_back({o1, r1});
        exp2_q.push_back({o2, r2});
        cyc(LOUT);
        exp_cnt = 0;
        check("addr_clear", {29'd0, addr1}, 0);
        check("cmp_clear", {31'd0, cmp1}, 0);
    endtask

    always @(negedge clk) begin
        if (rv1) begin
            if (exp1_q.size() == 0) check("rv1_unexpected", 1, 0);
            else begin
                logic [19:0] e;
                e = exp1_q.pop_front();
                check("result1", {13'd0, result1}, {13'd0, e[18:0]});
                check("ovf1_with_result", {31'd0, ovf1}, {31'd0, e[19]});
            end
        end
        if (rv2) begin
            if (exp2_q.size() == 0) check("rv2_unexpected", 1, 0);
            else begin
                logic [16:0] e;
                e = exp2_q.pop_front();
                check("result2", {16'd0, result2}, {16'd0, e[15:0]});
                check("ovf2_with_result", {31'd0, ovf2}, {31'd0, e[16]});
            end
        end
    end

    initial begin
        load_vec(32'h0, 32'h0);
        #1;
        check("rst_addr", {29'd0, addr1}, 0);
        check("rst_cmp", {31'd0, cmp1}, 0);
        check("rst_result", {13'd0, result1}, 0);
        check("rst_valid", {31'd0, rv1}, 0);
        check("rst_ovf", {31'd0, ovf2}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic dot product: 1*5+2*6+3*7+4*8 = 70
        load_vec(32'h04030201, 32'h08070605);
        feed(4);
        finish_op(19'd70, 1'b0, 16'd70, 1'b0);

        // Back-to-back: 1*9 = 9
        load_vec(32'h01000000, 32'h09090909);
        feed(4);
        finish_op(19'd9, 1'b0, 16'd9, 1'b0);

        // All 255: 4*65025 = 260100; 16-bit accumulator wraps to 63492
        load_vec(32'hFFFFFFFF, 32'hFFFFFFFF);
        feed(4);
        check("ovf2_live_sticky", {31'd0, ovf2}, 1);
        check("ovf1_live_clear", {31'd0, ovf1}, 0);
        finish_op(19'd260100, 1'b0, 16'd63492, 1'b1);
        cyc(6'd0);
        check("ovf2_cleared_after", {31'd0, ovf2}, 0);
        check("rv_one_cycle", {31'd0, rv1}, 0);

        // Saturation: extra count_enable after count reaches LEN
        load_vec(32'h04030201, 32'h08070605);
        feed(4);
        cyc(CE);
        cyc(CE);
        check("sat_addr", {29'd0, addr1}, 4);
        check("sat_cmp", {31'd0, cmp1}, 1);
        finish_op(19'd70, 1'b0, 16'd70, 1'b0);

        // Asynchronous reset between edges after two accumulations
        feed(2);
        #2 rst = 1'b1;
        #1;
        check("arst_addr", {29'd0, addr1}, 0);
        check("arst_result", {13'd0, result1}, 0);
        check("arst_valid", {31'd0, rv1}, 0);
        check("arst_cmp", {31'd0, cmp1}, 0);
        rst = 1'b0;
        @(negedge clk);
        exp_cnt = 0;
        feed(4);
        finish_op(19'd70, 1'b0, 16'd70, 1'b0);

        // Collision: load_out with load_acc and count_enable; m_reg still holds 32
        feed(4);
        exp1_q.push_back({1'b0, 19'd70});
        exp2_q.push_back({1'b0, 16'd70});
        cyc(LOUT | LACC | CE);
        exp_cnt = 0;
        check("coll_addr", {29'd0, addr1}, 0);
        finish_op(19'd0, 1'b0, 16'd0, 1'b0);

        repeat (3) cyc(6'd0);
        check("queue1_drained", exp1_q.size(), 0);
        check("queue2_drained", exp2_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
